filtro_ctrl_pb200: RTL and testbench
====================================

Name: filtro_ctrl_pb200

Overview:
Control unit that sequences the multiplexed biquad datapath (the low-pass filter stage) once per input sample. It consumes a one-cycle sample strobe and drives the datapath's register enables en1..en7 and mux selects selmuxS/selmuxC/selmuxZ. It runs the five multiply-accumulate steps plus the delay-line shift, then reports completion. It sits directly upstream of the datapath's control inputs and shares its clock and reset.

Parameters:
ARIT_LAT, 2, cycles from mux select change to valid resarit at the arithmetic unit output; legal range 0..7.

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
start  input  1  sample strobe, one-cycle pulse; new uk valid at the datapath input
en1  output  1  Y(k) register load
en2  output  1  F(k) register load
en3  output  1  F(k-1) register load
en4  output  1  F(k-2) register load
en5  output  1  acumulador 1 load
en6  output  1  acumulador 2 load
en7  output  1  acumulador 3 load
selmuxS  output  3  signal mux select: 0=fk, 1=fk1, 2=fk2, 3=yk, 4=uk
selmuxC  output  2  coefficient mux select: 0=b0 (= b2, symmetric), 1=b1, 2=-a1, 3=-a2
selmuxZ  output  3  addend mux select: 0=zero, 1=uk, 2=acum1, 3=acum2, 4=acum3, 5=yk
busy  output  1  sequence in progress
done  output  1  one-cycle pulse; yk holds the new output
overrun  output  1  sticky; start arrived while busy

Behaviour:
- Datapath operation: resarit = S*C + Z, available ARIT_LAT cycles after the selects are applied.
- States: IDLE, STEP (sub-counter 0..ARIT_LAT, step counter 1..5), SHIFT, DONE.
- Reset (reset=0 at an edge):
  - Next cycle: state IDLE, counters 0.
  - All en* = 0, all selects = 0, busy = 0, done = 0, overrun = 0.
  - Reset has priority over start and aborts any sequence in progress.
- IDLE: all outputs 0 except overrun. start=1 sampled in cycle 0 → STEP 1 in cycle 1.
- STEP s:
  - Occupies ARIT_LAT+1 cycles; selects are constant for the whole step.
  - The step's single enable is asserted only in the step's last cycle, when sub-counter = ARIT_LAT.
  - Step table (S, C, Z → enable):
    - 1: S=1, C=2, Z=1 → en5
    - 2: S=2, C=3, Z=2 → en2
    - 3: S=0, C=0, Z=0 → en6
    - 4: S=1, C=1, Z=3 → en7
    - 5: S=2, C=0, Z=4 → en1
  - Step s spans cycles (s-1)(ARIT_LAT+1)+1 .. s(ARIT_LAT+1).
- SHIFT: one cycle with en3=en4=1 simultaneously (fk2←fk1, fk1←fk on the same edge); selects 0.
- DONE: one cycle with done=1, busy=0, selects 0, no enables.
  - start=1 in DONE is accepted exactly as in IDLE (next cycle is STEP 1).
  - Otherwise the next state is IDLE.
- busy = 1 in STEP and SHIFT only.
- Latency: start in cycle 0 → done in cycle 5(ARIT_LAT+1)+2; for ARIT_LAT=2 that is cycle 17. New yk is visible from cycle 16.
- Enables:
  - At most one en* is high per cycle, except SHIFT (en3 and en4 together).
  - en* is never high in IDLE or DONE.
- Overrun:
  - start=1 while busy=1 is ignored; the schedule continues unchanged.
  - overrun goes to 1 on the next cycle and holds until reset.
- Selects return to 0 whenever no step is active.

Test Plan:
1. reset=0 for 3 cycles with start=1 → every output 0 throughout and one cycle after reset is released.
2. ARIT_LAT=2, start pulse in cycle 0 →
   - en5 in cycle 3, en2 in cycle 6, en6 in cycle 9, en7 in cycle 12, en1 in cycle 15.
   - en3+en4 in cycle 16, done in cycle 17.
   - busy=1 in cycles 1..16.
   - Selects match the step table in cycles 1-3, 4-6, 7-9, 10-12, 13-15.
3. start in cycle 0 and again in cycle 5 → overrun=1 from cycle 6 onward; the enable timeline is identical to scenario 2; no second done.
4. start in cycle 0 and again in cycle 17 (the DONE cycle) → second sequence: en5 in cycle 20, done in cycle 34; overrun stays 0.
5. start in cycle 0, reset=0 in cycle 8 →
   - Cycle 9: all outputs 0.
   - start in cycle 12 (with reset=1) → full sequence: en5 in cycle 15, done in cycle 29.
6. ARIT_LAT=0, start in cycle 0 → en5, en2, en6, en7, en1 in cycles 1..5; en3+en4 in cycle 6; done in cycle 7.

Source files
------------

// File: rtl/filtro_ctrl_pb200.sv
// filtro_ctrl_pb200: per-sample sequencer for the multiplexed biquad datapath (five MAC steps, delay-line shift, done pulse)
module filtro_ctrl_pb200 #(
  parameter int ARIT_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       en1,
  output logic       en2,
  output logic       en3,
  output logic       en4,
  output logic       en5,
  output logic       en6,
  output logic       en7,
  output logic [2:0] selmuxS,
  output logic [1:0] selmuxC,
  output logic [2:0] selmuxZ,
  output logic       busy,
  output logic       done,
  output logic       overrun
);
  typedef enum logic [1:0] {IDLE, STEP, SHIFT, DONE} state_t;
  localparam logic [2:0] LAT = 3'(ARIT_LAT);
  state_t     state_q, state_d;
  logic [2:0] step_q, step_d, sub_q, sub_d;
  logic [7:1] en_q, en_d;
  logic [2:0] sels_q, sels_d, selz_q, selz_d;
  logic [1:0] selc_q, selc_d;
  logic       busy_q, busy_d, done_q, done_d, ovr_q;
  logic       last, in_step, fin;
  assign last = sub_q == LAT;
  // Next state: a step lasts ARIT_LAT+1 cycles; DONE accepts start just like IDLE
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    sub_d   = sub_q;
    case (state_q)
      STEP: begin
        state_d = (last && step_q == 3'd5) ? SHIFT : STEP;
        step_d  = !last ? step_q : (step_q == 3'd5) ? 3'd0 : step_q + 3'd1;
        sub_d   = last ? 3'd0 : sub_q + 3'd1;
      end
      SHIFT: begin
        state_d = DONE;
        step_d  = 3'd0;
        sub_d   = 3'd0;
      end
      default: begin
        state_d = start ? STEP : IDLE;
        step_d  = start ? 3'd1 : 3'd0;
        sub_d   = 3'd0;
      end
    endcase
  end
  assign in_step = state_d == STEP;
  assign fin     = in_step && sub_d == LAT;
  // Output decode from the next state so every output is a plain register
  always_comb begin
    sels_d = !in_step ? 3'd0 : (step_d == 3'd1 || step_d == 3'd4) ? 3'd1 : (step_d == 3'd3) ? 3'd0 : 3'd2;
    selc_d = !in_step ? 2'd0 : (step_d == 3'd1) ? 2'd2 : (step_d == 3'd2) ? 2'd3 : (step_d == 3'd4) ? 2'd1 : 2'd0;
    selz_d = !in_step ? 3'd0 : (step_d == 3'd3) ? 3'd0 : (step_d >= 3'd4) ? step_d - 3'd1 : step_d;
    en_d[1] = fin && step_d == 3'd5;
    en_d[2] = fin && step_d == 3'd2;
    en_d[3] = state_d == SHIFT;
    en_d[4] = state_d == SHIFT;
    en_d[5] = fin && step_d == 3'd1;
    en_d[6] = fin && step_d == 3'd3;
    en_d[7] = fin && step_d == 3'd4;
    busy_d = in_step || state_d == SHIFT;
    done_d = state_d == DONE;
  end
  // State and registered outputs; reset aborts any sequence and clears the sticky overrun
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      step_q  <= 3'd0;
      sub_q   <= 3'd0;
      en_q    <= '0;
      sels_q  <= 3'd0;
      selc_q  <= 2'd0;
      selz_q  <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      sub_q   <= sub_d;
      en_q    <= en_d;
      sels_q  <= sels_d;
      selc_q  <= selc_d;
      selz_q  <= selz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_q | (start & busy_q);
    end
  end
  assign {en7, en6, en5, en4, en3, en2, en1} = en_q;
  assign selmuxS = sels_q;
  assign selmuxC = selc_q;
  assign selmuxZ = selz_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = ovr_q;
endmodule

// File: tb/tb_filtro_ctrl_pb200.sv
// tb_filtro_ctrl_pb200: scoreboard bench running the same stimulus into ARIT_LAT=2 and ARIT_LAT=0 instances
module tb_filtro_ctrl_pb200;
  typedef struct {
    int          cyc;
    logic [17:0] v;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic a1, a2, a3, a4, a5, a6, a7, ab, ad, ao;
  logic b1, b2, b3, b4, b5, b6, b7, bb, bd, bo;
  logic [2:0] as_, az, bs, bz;
  logic [1:0] ac, bc;
  logic [17:0] va, vb;
  exp_t q0[$], q1[$];
  int checks = 0;
  int failures = 0;
  int tbl_s[5] = '{1, 2, 0, 1, 2};
  int tbl_c[5] = '{2, 3, 0, 1, 0};
  int tbl_z[5] = '{1, 2, 0, 3, 4};
  int tbl_e[5] = '{5, 2, 6, 7, 1};
  always #5 clk = ~clk;
  filtro_ctrl_pb200 #(.ARIT_LAT(2)) dut0 (
    .clk(clk), .reset(rst_n), .start(start),
    .en1(a1), .en2(a2), .en3(a3), .en4(a4), .en5(a5), .en6(a6), .en7(a7),
    .selmuxS(as_), .selmuxC(ac), .selmuxZ(az), .busy(ab), .done(ad), .overrun(ao)
  );
  filtro_ctrl_pb200 #(.ARIT_LAT(0)) dut1 (
    .clk(clk), .reset(rst_n), .start(start),
    .en1(b1), .en2(b2), .en3(b3), .en4(b4), .en5(b5), .en6(b6), .en7(b7),
    .selmuxS(bs), .selmuxC(bc), .selmuxZ(bz), .busy(bb), .done(bd), .overrun(bo)
  );
  assign va = {a1, a2, a3, a4, a5, a6, a7, as_, ac, az, ab, ad, ao};
  assign vb = {b1, b2, b3, b4, b5, b6, b7, bs, bc, bz, bb, bd, bo};
  // Expected outputs k cycles after an accepted start: steps, then shift, then done
  function automatic logic [17:0] model(input int lat, input int k, input bit ovr);
    logic [6:0] en = '0;
    logic [2:0] s = '0, z = '0;
    logic [1:0] c = '0;
    bit b = 0, dn = 0;
    int p = lat + 1;
    if (k >= 1 && k <= 5 * p) begin
      int i = (k - 1) / p;
      b = 1;
      s = 3'(tbl_s[i]);
      c = 2'(tbl_c[i]);
      z = 3'(tbl_z[i]);
      if ((k - 1) % p == lat) en[7 - tbl_e[i]] = 1'b1;
    end else if (k == 5 * p + 1) begin
      b = 1;
      en[7 - 3] = 1'b1;
      en[7 - 4] = 1'b1;
    end else if (k == 5 * p + 2) begin
      dn = 1;
    end
    return {en, s, c, z, b, dn, ovr};
  endfunction
  function automatic bit rst_low(input int c);
    return c <= 2 || c == 70 || c == 138;
  endfunction
  function automatic bit start_at(input int c);
    return c <= 2 || c == 10 || c == 40 || c == 45 || c == 80 || c == 97 || c == 130 || c == 142;
  endfunction
  // Stimulus: drive one cycle's inputs and push what each DUT must show in that cycle
  initial begin
    int  seq[2] = '{-1000, -1000};
    bit  ovr[2] = '{0, 0};
    bit  pbusy[2] = '{0, 0};
    int  lat[2] = '{2, 0};
    bit  prev_rst = 0, prev_st = 0;
    exp_t e;
    for (int c = 0; c <= 175; c++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (!prev_rst) begin
          seq[d] = -1000;
          ovr[d] = 0;
        end else if (prev_st) begin
          if (pbusy[d]) ovr[d] = 1;
          else seq[d] = c - 1;
        end
        e.cyc = c;
        e.v = model(lat[d], c - seq[d], ovr[d]);
        pbusy[d] = e.v[2];
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
      end
      rst_n = !rst_low(c);
      start = start_at(c);
      prev_rst = rst_n;
      prev_st = start;
    end
    for (int i = 0; i < 5 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL drain pending0=%0d pending1=%0d required 0", q0.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  // Monitor: compare each DUT against the oldest pending expectation mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() != 0) begin
      e = q0.pop_front();
      checks++;
      if (va !== e.v) begin
        failures++;
        $display("FAIL lat2 cyc%0d got=%b exp=%b", e.cyc, va, e.v);
      end
    end
    if (q1.size() != 0) begin
      e = q1.pop_front();
      checks++;
      if (vb !== e.v) begin
        failures++;
        $display("FAIL lat0 cyc%0d got=%b exp=%b", e.cyc, vb, e.v);
      end
    end
  end
endmodule
